// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for a shared 3-state bus. Inserts TURN_CYCLES idle
// cycles between any two owners so registered bus drivers never overlap.
module bus_arbiter #(
    parameter int N           = 4,
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1,
    localparam int OW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  en,
    output logic [OW-1:0] owner,
    output logic          busy,
    output logic          turn
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  en_q, en_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [7:0]    hold_q, hold_d;
    logic [1:0]    tcnt_q, tcnt_d;
    logic          busy_q, busy_d;
    logic          turn_q, turn_d;

    logic [OW-1:0] win, idx;
    logic          found;
    logic          others;
    logic          hold_max;
    logic          load;

    // Search starts one past the last owner, so it has lowest priority.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = OW'((int'(owner_q) + i) % N);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        others = 1'b0;
        for (int i = 0; i < N; i++)
            if (OW'(i) != owner_q && req[i]) others = 1'b1;
    end

    assign hold_max = (hold_q == 8'(MAX_HOLD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    hold_d  = 8'd1;
                end
            end
            GRANT: begin
                if (!req[owner_q] || (hold_max && others)) begin
                    state_d = TURN;
                    tcnt_d  = 2'd1;
                end else if (hold_max) begin
                    hold_d = 8'd1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            TURN: begin
                if (tcnt_q == 2'(TURN_CYCLES)) begin
                    if (|req) begin
                        state_d = GRANT;
                        hold_d  = 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new owner is only ever loaded when entering GRANT from IDLE or TURN.
    always_comb begin
        load    = (state_d == GRANT) && (state_q != GRANT);
        owner_d = load ? win : owner_q;
        en_d    = '0;
        if (state_d == GRANT) en_d[owner_d] = 1'b1;
        busy_d  = (state_d == GRANT);
        turn_d  = (state_d == TURN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= '0;
            owner_q <= OW'(N - 1);
            hold_q  <= '0;
            tcnt_q  <= '0;
            busy_q  <= 1'b0;
            turn_q  <= 1'b0;
        end else begin
            en_q    <= en_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            tcnt_q  <= tcnt_d;
            busy_q  <= busy_d;
            turn_q  <= turn_d;
        end
    end

    assign en    = en_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign turn  = turn_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one instance with single-cycle turnaround,
// one with three cycles plus a registered bus-user drive model.
module tb_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0, req3 = '0;
    logic [3:0] en, en3;
    logic [1:0] owner, owner3;
    logic       busy, busy3, turn, turn3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .en(en), .owner(owner), .busy(busy), .turn(turn));
    bus_arbiter #(.N(4), .MAX_HOLD(8), .TURN_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .en(en3), .owner(owner3), .busy(busy3), .turn(turn3));

    // Bus users register their enable; a driver stays on one cycle after en falls.
    logic [3:0] drv3;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) drv3 <= '0;
        else        drv3 <= en3;

    logic [3:0] prev_en = '0, prev_en3 = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if (!$onehot0(en) || !$onehot0(en3)) begin
                miscompares++;
                $display("FAIL onehot0 en=%b en3=%b", en, en3);
            end
            if ((prev_en != 0 && en != 0 && en != prev_en) ||
                (prev_en3 != 0 && en3 != 0 && en3 != prev_en3)) begin
                miscompares++;
                $display("FAIL no_turnaround en %b->%b en3 %b->%b", prev_en, en, prev_en3, en3);
            end
            if ($countones(drv3) > 1) begin
                miscompares++;
                $display("FAIL bus_contention drivers=%b", drv3);
            end
        end
        prev_en  = en;
        prev_en3 = en3;
    end

    task automatic chk(input string name, input logic [3:0] e, input logic [1:0] o,
                       input logic b, input logic t);
        vectors++;
        if (en !== e || owner !== o || busy !== b || turn !== t) begin
            miscompares++;
            $display("FAIL %s got en=%b owner=%0d busy=%b turn=%b want en=%b owner=%0d busy=%b turn=%b",
                     name, en, owner, busy, turn, e, o, b, t);
        end
    endtask

    task automatic chk3(input string name, input logic [3:0] e, input logic [1:0] o, input logic t);
        vectors++;
        if (en3 !== e || owner3 !== o || turn3 !== t || busy3 !== (e != 0)) begin
            miscompares++;
            $display("FAIL %s got en3=%b owner3=%0d turn3=%b busy3=%b want en3=%b owner3=%0d turn3=%b",
                     name, en3, owner3, turn3, busy3, e, o, t);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = '0;
        req3  = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
        end
    endtask

    task automatic test_single_hold();
        req = 4'b0100;
        @(negedge clk);
        chk("single_first", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("single_hold_wrap", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        req = 4'b0000;
        @(negedge clk);
        chk("single_release_turn", 4'b0000, 2'd2, 1'b0, 1'b1);
        @(negedge clk);
        chk("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    endtask

    task automatic test_rr_preempt();
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_owner0", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        @(negedge clk);
        chk("rr_turn_a", 4'b0000, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_owner1", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        @(negedge clk);
        chk("rr_turn_b", 4'b0000, 2'd1, 1'b0, 1'b1);
        @(negedge clk);
        chk("rr_back_to_0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_drop_owner();
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        chk("drop_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1001;
        @(negedge clk);
        chk("drop_turn", 4'b0000, 2'd2, 1'b0, 1'b1);
        @(negedge clk);
        chk("drop_next3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_turn3();
        do_reset();
        req3 = 4'b0011;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk3("t3_grant", (r == 0) ? 4'b0001 : 4'b0010, 2'(r), 1'b0);
            end
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk3("t3_gap", 4'b0000, 2'(r), 1'b1);
            end
        end
        @(negedge clk);
        chk3("t3_back_to_0", 4'b0001, 2'd0, 1'b0);
        req3 = 4'b0000;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        chk("ar_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("ar_mid_cycle", 4'b0000, 2'd3, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_rr_preempt();
        test_drop_owner();
        test_turn3();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
